// File: rtl/vwb_pkg.sv
// vwb_pkg: shared window defaults, lane helper and drain FSM states for the video write buffer.
package vwb_pkg;
  localparam logic [31:0] VWB_WIN_BASE  = 32'h0000_8000;
  localparam logic [31:0] VWB_WIN_LIMIT = 32'h0001_FFFF;
  typedef enum logic [1:0] {IDLE, DRAIN, DONE} vwb_state_e;
  function automatic int vwb_lanes(input int data_w);
    return data_w / 8;
  endfunction
endpackage

// File: rtl/vwb_fifo_mem.sv
// vwb_fifo_mem: entry storage with a push port and a read-modify-write merge port on the newest entry.
module vwb_fifo_mem
  import vwb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 8,
  localparam int PW = $clog2(DEPTH),
  localparam int NL = vwb_lanes(DATA_W)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [PW-1:0]     wr_ptr,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [NL-1:0]     wr_be,
  input  logic              mrg_en,
  input  logic [PW-1:0]     mrg_ptr,
  input  logic [DATA_W-1:0] mrg_data,
  input  logic [NL-1:0]     mrg_be,
  output logic [ADDR_W-1:0] mrg_addr,
  input  logic [PW-1:0]     rd_ptr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [NL-1:0]     rd_be
);
  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [NL-1:0]     mem_be   [DEPTH];
  logic [DATA_W-1:0] mrg_word;
  assign mrg_addr = mem_addr[mrg_ptr];
  assign rd_addr  = mem_addr[rd_ptr];
  assign rd_data  = mem_data[rd_ptr];
  assign rd_be    = mem_be[rd_ptr];
  always_comb begin
    mrg_word = mem_data[mrg_ptr];
    for (int i = 0; i < NL; i++)
      if (mrg_be[i]) mrg_word[i*8 +: 8] = mrg_data[i*8 +: 8];
  end
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_addr[wr_ptr] <= wr_addr;
      mem_data[wr_ptr] <= wr_data;
      mem_be[wr_ptr]   <= wr_be;
    end
    if (mrg_en) begin
      mem_data[mrg_ptr] <= mrg_word;
      mem_be[mrg_ptr]   <= mem_be[mrg_ptr] | mrg_be;
    end
  end
endmodule

// File: rtl/video_write_buffer.sv
// video_write_buffer: windowed, optionally coalescing store FIFO from MEM stage to video sink with drain handshake.
module video_write_buffer
  import vwb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 8,
  parameter logic [ADDR_W-1:0] WIN_BASE  = ADDR_W'(VWB_WIN_BASE),
  parameter logic [ADDR_W-1:0] WIN_LIMIT = ADDR_W'(VWB_WIN_LIMIT),
  parameter int COALESCE = 1,
  localparam int NL = vwb_lanes(DATA_W),
  localparam int PW = $clog2(DEPTH),
  localparam int LW = PW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic [NL-1:0]     in_be,
  output logic              in_ready,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic [NL-1:0]     out_be,
  input  logic              out_ready,
  input  logic              drain_req,
  output logic              drained,
  output logic [LW-1:0]     level,
  output logic [LW-1:0]     hwm,
  output logic [15:0]       coalesce_cnt
);
  vwb_state_e state, state_nxt;
  logic [PW-1:0] head, tail, newest;
  logic [ADDR_W-1:0] waddr, nw_addr;
  logic [LW-1:0] level_nxt;
  logic hit, acc, pop, merge, push;
  assign waddr     = in_addr & ~ADDR_W'(NL - 1);
  assign newest    = tail - PW'(1);
  assign hit       = in_addr >= WIN_BASE && in_addr <= WIN_LIMIT;
  assign in_ready  = level != LW'(DEPTH) && state == IDLE;
  assign out_valid = level != '0;
  assign pop       = out_valid && out_ready;
  assign acc       = in_valid && hit && in_ready;
  // A lone entry leaving this cycle cannot absorb the store; it must be pushed instead.
  assign merge     = COALESCE != 0 && acc && out_valid && nw_addr == waddr && !(level == LW'(1) && pop);
  assign push      = acc && !merge;
  assign level_nxt = level + LW'(push) - LW'(pop);
  assign drained   = state == DONE;
  always_comb
    state_nxt = state == IDLE ? (drain_req ? DRAIN : IDLE) :
                !drain_req ? IDLE :
                (state == DRAIN && level_nxt == '0) ? DONE : state;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      head         <= '0;
      tail         <= '0;
      level        <= '0;
      hwm          <= '0;
      coalesce_cnt <= '0;
      state        <= IDLE;
    end else begin
      head         <= head + PW'(pop);
      tail         <= tail + PW'(push);
      level        <= level_nxt;
      hwm          <= level_nxt > hwm ? level_nxt : hwm;
      coalesce_cnt <= coalesce_cnt + 16'(merge && coalesce_cnt != 16'hFFFF);
      state        <= state_nxt;
    end
  vwb_fifo_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_mem (
    .clk      (clk),
    .wr_en    (push),
    .wr_ptr   (tail),
    .wr_addr  (waddr),
    .wr_data  (in_data),
    .wr_be    (in_be),
    .mrg_en   (merge),
    .mrg_ptr  (newest),
    .mrg_data (in_data),
    .mrg_be   (in_be),
    .mrg_addr (nw_addr),
    .rd_ptr   (head),
    .rd_addr  (out_addr),
    .rd_data  (out_data),
    .rd_be    (out_be)
  );
endmodule
